// File: rtl/wb_queue.sv
// wb_queue: writeback queue draining into the register file write port, with operand forwarding.
// Define WBQ_COALESCE_EN to merge a push into the youngest entry when its destination matches.
module wb_queue #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [4:0]       push_uop,
    input  logic [3:0]       push_sel,
    input  logic [31:0]      push_data,
    input  logic [3:0]       push_flags,
    input  logic             drain_hold,
    output logic             rf_not_enable,
    output logic [4:0]       rf_uop,
    output logic [3:0]       rf_sel_in,
    output logic [31:0]      rf_in_reg,
    output logic [3:0]       rf_in_flags,
    input  logic [3:0]       look_sel_p0,
    input  logic [3:0]       look_sel_p1,
    output logic             hit_p0,
    output logic             hit_p1,
    output logic [31:0]      fwd_p0,
    output logic [31:0]      fwd_p1,
    output logic             flags_hit,
    output logic [3:0]       fwd_flags,
    output logic             pc_write_err,
    output logic [PTR_W:0]   count,
    output logic             empty
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [3:0]       sel_q   [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [3:0]       flags_q [DEPTH];
    logic [4:0]       uop_q   [DEPTH];
    logic [PTR_W-1:0] head, tail, tail_m1, wr_idx, idx;
    logic             fire, discard, store, coalesce, alloc, pop;

    assign tail_m1       = tail - PTR_W'(1);
    assign empty         = reset | (count == '0);
    assign flags_hit     = !empty;
    assign rf_not_enable = empty | drain_hold;
    assign pop           = !rf_not_enable;
    assign rf_uop        = uop_q[head];
    assign rf_sel_in     = sel_q[head];
    assign rf_in_reg     = data_q[head];
    assign rf_in_flags   = flags_q[head];
    assign fwd_flags     = empty ? 4'd0 : flags_q[tail_m1];
    assign fire          = push_valid & push_ready;
    // NOP/CMP/STR produce no register result
    assign discard       = (push_uop == 5'd0) | (push_uop == 5'd5) | (push_uop == 5'd9);
    assign store         = fire & !discard & (push_sel != 4'd15);
`ifdef WBQ_COALESCE_EN
    logic match;
    assign match      = !empty & (sel_q[tail_m1] == push_sel);
    assign push_ready = !reset & ((count < FULL) | match);
    // a lone head leaving this cycle cannot absorb the push
    assign coalesce   = store & match & !((count == (PTR_W+1)'(1)) & pop);
`else
    assign push_ready = !reset & (count < FULL);
    assign coalesce   = 1'b0;
`endif
    assign alloc  = store & !coalesce;
    assign wr_idx = coalesce ? tail_m1 : tail;

    always_ff @(posedge clock) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            pc_write_err <= 1'b0;
        end else begin
            head         <= pop ? head + PTR_W'(1) : head;
            tail         <= alloc ? tail + PTR_W'(1) : tail;
            count        <= count + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);
            pc_write_err <= fire & !discard & (push_sel == 4'd15);
        end
    end

    always_ff @(posedge clock) begin
        if (store) begin
            sel_q[wr_idx]   <= push_sel;
            data_q[wr_idx]  <= push_data;
            flags_q[wr_idx] <= push_flags;
            uop_q[wr_idx]   <= push_uop;
        end
    end

    // walk oldest to youngest so the youngest match wins
    always_comb begin
        hit_p0 = 1'b0;
        hit_p1 = 1'b0;
        fwd_p0 = '0;
        fwd_p1 = '0;
        idx    = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (!reset && ((PTR_W+1)'(i) < count)) begin
                if (sel_q[idx] == look_sel_p0) begin
                    hit_p0 = 1'b1;
                    fwd_p0 = data_q[idx];
                end
                if (sel_q[idx] == look_sel_p1) begin
                    hit_p1 = 1'b1;
                    fwd_p1 = data_q[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed and random stimulus against a queue-based reference model of wb_queue.
module tb_wb_queue;
    logic        clock, reset, push_valid, push_ready, drain_hold, rf_not_enable;
    logic [4:0]  push_uop, rf_uop;
    logic [3:0]  push_sel, push_flags, rf_sel_in, rf_in_flags, look_sel_p0, look_sel_p1, fwd_flags;
    logic [31:0] push_data, rf_in_reg, fwd_p0, fwd_p1;
    logic        hit_p0, hit_p1, flags_hit, pc_write_err, empty;
    logic [2:0]  count;

    wb_queue #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset), .push_valid(push_valid), .push_ready(push_ready),
        .push_uop(push_uop), .push_sel(push_sel), .push_data(push_data), .push_flags(push_flags),
        .drain_hold(drain_hold), .rf_not_enable(rf_not_enable), .rf_uop(rf_uop),
        .rf_sel_in(rf_sel_in), .rf_in_reg(rf_in_reg), .rf_in_flags(rf_in_flags),
        .look_sel_p0(look_sel_p0), .look_sel_p1(look_sel_p1), .hit_p0(hit_p0), .hit_p1(hit_p1),
        .fwd_p0(fwd_p0), .fwd_p1(fwd_p1), .flags_hit(flags_hit), .fwd_flags(fwd_flags),
        .pc_write_err(pc_write_err), .count(count), .empty(empty)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] data;
        logic [3:0]  flags;
        logic [4:0]  uop;
    } ent_t;

    ent_t q[$];
    logic exp_pc_err = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, clock, advance the model.
    task automatic step(input logic v, input logic [4:0] u, input logic [3:0] s, input logic [31:0] d,
                        input logic [3:0] f, input logic h, input logic [3:0] l0, input logic [3:0] l1,
                        input logic r);
        logic ready, ne, match, co, h0, h1;
        logic [31:0] f0, f1;
        int n;
        reset = r; push_valid = v; push_uop = u; push_sel = s; push_data = d; push_flags = f;
        drain_hold = h; look_sel_p0 = l0; look_sel_p1 = l1;
        #4;
        n = q.size();
        match = (n > 0) && (q[n-1].sel == s);
        ready = !r && (n < 4);
`ifdef WBQ_COALESCE_EN
        ready = ready || (!r && match);
`endif
        ne = r || (n == 0) || h;
        h0 = 1'b0; h1 = 1'b0; f0 = '0; f1 = '0;
        foreach (q[k]) begin
            if (q[k].sel == l0) begin h0 = 1'b1; f0 = q[k].data; end
            if (q[k].sel == l1) begin h1 = 1'b1; f1 = q[k].data; end
        end
        check("push_ready", push_ready, ready);
        check("rf_not_enable", rf_not_enable, ne);
        if (r) begin
            check("empty_rst", empty, 1);
            check("hit_p0_rst", hit_p0, 0);
            check("hit_p1_rst", hit_p1, 0);
            check("flags_hit_rst", flags_hit, 0);
        end else begin
            check("pc_write_err", pc_write_err, exp_pc_err);
            check("count", count, n);
            check("empty", empty, n == 0);
            check("hit_p0", hit_p0, h0);
            check("fwd_p0", fwd_p0, f0);
            check("hit_p1", hit_p1, h1);
            check("fwd_p1", fwd_p1, f1);
            check("flags_hit", flags_hit, n > 0);
            check("fwd_flags", fwd_flags, n > 0 ? q[n-1].flags : 4'd0);
            if (n > 0) begin
                check("rf_sel_in", rf_sel_in, q[0].sel);
                check("rf_in_reg", rf_in_reg, q[0].data);
                check("rf_in_flags", rf_in_flags, q[0].flags);
                check("rf_uop", rf_uop, q[0].uop);
            end
        end
        @(posedge clock);
        exp_pc_err = 1'b0;
        if (r) q.delete();
        else begin
            co = 1'b0;
`ifdef WBQ_COALESCE_EN
            co = match && !(n == 1 && !ne);
`endif
            if (!ne) void'(q.pop_front());
            if (v && ready && !(u inside {5'd0, 5'd5, 5'd9})) begin
                if (s == 4'd15) exp_pc_err = 1'b1;
                else if (co) q[q.size()-1] = '{s, d, f, u};
                else q.push_back('{s, d, f, u});
            end
        end
        #1;
    endtask

    task automatic idle(input logic h);
        step(0, 5'd1, 4'd0, 0, 4'd0, h, 4'd0, 4'd0, 0);
    endtask

    initial begin
        logic v, h, r;
        logic [4:0] u;
        logic [3:0] s, f, l0, l1;
        logic [31:0] d;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("reset_count", count, 0);
        check("reset_pc_err", pc_write_err, 0);

        step(1, 5'd1, 4'd3, 32'h12345678, 4'h8, 0, 4'd3, 4'd0, 0);
        check("single_count", count, 1);
        check("single_sel", rf_sel_in, 3);
        check("single_data", rf_in_reg, 32'h12345678);
        idle(0);
        check("single_empty", empty, 1);

        for (int i = 1; i <= 4; i++) step(1, 5'd2, 4'(i), 32'h100 + i, 4'(i), 1, 4'(i), 4'd2, 0);
        check("full_count", count, 4);
        check("full_ready", push_ready, 0);
        step(1, 5'd2, 4'd9, 32'hdead, 4'd1, 1, 4'd1, 4'd4, 0);
        for (int i = 0; i < 4; i++) idle(0);
        check("drained_empty", empty, 1);

        step(1, 5'd5, 4'd2, 32'h1, 4'd0, 0, 4'd2, 4'd0, 0);
        step(1, 5'd0, 4'd2, 32'h2, 4'd0, 0, 4'd2, 4'd0, 0);
        step(1, 5'd9, 4'd2, 32'h3, 4'd0, 0, 4'd2, 4'd0, 0);
        check("discard_count", count, 0);
        step(1, 5'd1, 4'd15, 32'h4, 4'd0, 0, 4'd15, 4'd0, 0);
        check("pc_err_count", count, 0);
        check("pc_err_pulse", pc_write_err, 1);
        idle(0);
        check("pc_err_clear", pc_write_err, 0);

        step(1, 5'd1, 4'd7, 32'hA, 4'd1, 1, 4'd7, 4'd6, 0);
        step(1, 5'd1, 4'd7, 32'hB, 4'd2, 1, 4'd7, 4'd6, 0);
        look_sel_p0 = 4'd7; look_sel_p1 = 4'd6;
        #1;
        check("fwd_hit_p0", hit_p0, 1);
        check("fwd_val_p0", fwd_p0, 32'hB);
        check("fwd_hit_p1", hit_p1, 0);
        check("fwd_val_p1", fwd_p1, 0);
        idle(0); idle(0); idle(0);

        for (int i = 1; i <= 4; i++) step(1, 5'd3, 4'(i), 32'h200 + i, 4'd0, 1, 4'(i), 4'd6, 0);
        step(1, 5'd3, 4'd6, 32'h300, 4'd5, 0, 4'd6, 4'd4, 0);
        check("wrap_count", count, 3);
        step(1, 5'd3, 4'd6, 32'h301, 4'd5, 0, 4'd6, 4'd4, 0);
        check("wrap_count2", count, 3);
        for (int i = 0; i < 4; i++) idle(0);

        step(1, 5'd1, 4'd5, 32'h1, 4'd1, 1, 4'd5, 4'd0, 0);
        step(1, 5'd1, 4'd5, 32'h2, 4'd2, 1, 4'd5, 4'd0, 0);
`ifdef WBQ_COALESCE_EN
        check("coalesce_count", count, 1);
`else
        check("coalesce_count", count, 2);
`endif
        idle(0); idle(0);

        step(1, 5'd1, 4'd1, 32'h11, 4'd1, 1, 4'd1, 4'd0, 0);
        step(1, 5'd1, 4'd2, 32'h22, 4'd2, 1, 4'd1, 4'd2, 0);
        idle(0);
        step(0, 5'd1, 4'd0, 0, 4'd0, 0, 4'd2, 4'd0, 1);
        check("rst_drop_count", count, 0);
        check("rst_drop_empty", empty, 1);

        for (int i = 0; i < 600; i++) begin
            v  = $urandom_range(3) != 0;
            u  = 5'($urandom_range(11));
            s  = ($urandom_range(15) == 0) ? 4'd15 : 4'($urandom_range(7));
            d  = $urandom;
            f  = 4'($urandom_range(15));
            h  = $urandom_range(1) == 1;
            l0 = 4'($urandom_range(7));
            l1 = 4'($urandom_range(7));
            r  = $urandom_range(99) == 0;
            step(v, u, s, d, f, h, l0, l1, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
